data_mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared 256x8 data memory. It lets the CPU data path (port A) and a secondary master (port B, e.g. a DMA or debug loader) share one `data_mem` instance. It serialises their read/write requests with round-robin priority and drives the memory's busy_wait handshake. It returns a per-port busy_wait that stalls the PC and register file exactly as the memory does today.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/arb_timeout_counter.sv | 33 +++
 rtl/data_mem_arbiter.sv | 122 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data memory arbiter.
// Widths default to the 256x8 data memory.
package mem_arb_pkg;

  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/arb_timeout_counter.sv
// Per-phase watchdog for the arbiter: counts cycles spent waiting on the memory.
// expired flags the cycle whose increment makes the count reach TIMEOUT.
module arb_timeout_counter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // NOTE: state uses non-blocking assignments and an asynchronous active-low
  // reset in the sensitivity list, so every flop clears the moment reset falls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and sequencer letting two masters share one data_mem,
// returning a per-port busy_wait that mimics the memory's own stall.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [DATA_W-1:0] a_write_data,
  output logic [DATA_W-1:0] a_read_data,
  output logic              a_busy_wait,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [DATA_W-1:0] b_write_data,
  output logic [DATA_W-1:0] b_read_data,
  output logic              b_busy_wait,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_busy_wait,
  output logic              timeout_err
);

  state_t state;
  logic   last_grant;  // doubles as the id of the port currently being served
  logic   win_port;
  logic   tmo_expired;

  // Both strobes high is as meaningless as both low, so XOR is the request.
  logic a_valid, b_valid;
  assign a_valid = a_read ^ a_write;
  assign b_valid = b_read ^ b_write;

  assign a_busy_wait = a_valid && !(state == DONE && last_grant == PORT_A);
  assign b_busy_wait = b_valid && !(state == DONE && last_grant == PORT_B);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win_port = PORT_A;
    if (a_valid && b_valid) begin
      win_port = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (b_valid) begin
      win_port = PORT_B;
    end
  end

  logic tmo_clear, tmo_enable;
  assign tmo_clear  = (state == ISSUE) || (state == WAIT_ACK && mem_busy_wait);
  assign tmo_enable = (state == WAIT_ACK) || (state == WAIT_DONE);

  arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmo_clear),
    .enable  (tmo_enable),
    .expired (tmo_expired)
  );

  // A clean finish in WAIT_DONE wins over a simultaneous timeout.
  logic done_ok, abort, finish;
  assign done_ok = (state == WAIT_DONE) && !mem_busy_wait;
  assign abort   = tmo_expired && !done_ok &&
                   ((state == WAIT_ACK && !mem_busy_wait) || state == WAIT_DONE);
  assign finish  = done_ok || abort;

  logic [DATA_W-1:0] rd_value;
  assign rd_value = abort ? '0 : mem_read_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      last_grant     <= PORT_B;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      a_read_data    <= '0;
      b_read_data    <= '0;
      timeout_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Holding off while the memory is busy lets an access orphaned by reset drain.
          if (!mem_busy_wait && (a_valid || b_valid)) begin
            state          <= ISSUE;
            last_grant     <= win_port;
            mem_address    <= (win_port == PORT_A) ? a_address    : b_address;
            mem_write_data <= (win_port == PORT_A) ? a_write_data : b_write_data;
            mem_read       <= (win_port == PORT_A) ? a_read       : b_read;
            mem_write      <= (win_port == PORT_A) ? a_write      : b_write;
          end
        end
        ISSUE:     state <= WAIT_ACK;
        WAIT_ACK:  if (mem_busy_wait) state <= WAIT_DONE;
        WAIT_DONE: ;
        DONE:      state <= IDLE;
        default:   state <= IDLE;
      endcase

      if (finish) begin
        state     <= DONE;
        mem_read  <= 1'b0;
        mem_write <= 1'b0;
        if (mem_read) begin
          if (last_grant == PORT_A) a_read_data <= rd_value;
          else                      b_read_data <= rd_value;
        end
        if (abort) timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: a busy-wait memory model on the main
// instance, and a second instance with TIMEOUT = 8 for the abort path.
module tb_data_mem_arbiter;

  localparam int N = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       a_read, a_write, b_read, b_write;
  logic [7:0] a_address, a_write_data, b_address, b_write_data;
  logic [7:0] a_read_data, b_read_data;
  logic       a_busy_wait, b_busy_wait;
  logic       mem_read, mem_write;
  logic [7:0] mem_address, mem_write_data;
  logic [7:0] mem_read_data = 8'h00;
  logic       mem_busy_wait;
  logic       timeout_err;

  data_mem_arbiter u_dut (
    .clk(clk), .reset(reset),
    .a_read(a_read), .a_write(a_write), .a_address(a_address),
    .a_write_data(a_write_data), .a_read_data(a_read_data), .a_busy_wait(a_busy_wait),
    .b_read(b_read), .b_write(b_write), .b_address(b_address),
    .b_write_data(b_write_data), .b_read_data(b_read_data), .b_busy_wait(b_busy_wait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .mem_busy_wait(mem_busy_wait), .timeout_err(timeout_err)
  );

  logic       t_a_read, t_a_write;
  logic [7:0] t_a_address, t_a_write_data, t_a_read_data;
  logic       t_a_busy_wait;
  logic       t_b_read = 1'b0, t_b_write = 1'b0;
  logic [7:0] t_b_address = 8'h00, t_b_write_data = 8'h00, t_b_read_data;
  logic       t_b_busy_wait;
  logic       t_mem_read, t_mem_write;
  logic [7:0] t_mem_address, t_mem_write_data;
  logic [7:0] t_mem_read_data = 8'h00;
  logic       t_mem_busy_wait;
  logic       t_timeout_err;

  data_mem_arbiter #(.TIMEOUT(8)) u_dut_to (
    .clk(clk), .reset(reset),
    .a_read(t_a_read), .a_write(t_a_write), .a_address(t_a_address),
    .a_write_data(t_a_write_data), .a_read_data(t_a_read_data), .a_busy_wait(t_a_busy_wait),
    .b_read(t_b_read), .b_write(t_b_write), .b_address(t_b_address),
    .b_write_data(t_b_write_data), .b_read_data(t_b_read_data), .b_busy_wait(t_b_busy_wait),
    .mem_read(t_mem_read), .mem_write(t_mem_write), .mem_address(t_mem_address),
    .mem_write_data(t_mem_write_data), .mem_read_data(t_mem_read_data),
    .mem_busy_wait(t_mem_busy_wait), .timeout_err(t_timeout_err)
  );

  // Main memory model: one cycle after seeing a strobe it goes busy for N cycles,
  // then performs the access and stays idle until the strobes drop.
  logic [7:0] mem [256];
  logic       m_busy = 1'b0, m_served = 1'b0;
  int         m_cnt = 0;
  assign mem_busy_wait = m_busy;

  always @(posedge clk) begin
    if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy   <= 1'b0;
        m_served <= 1'b1;
        if (mem_write) mem[mem_address] <= mem_write_data;
        else           mem_read_data    <= mem[mem_address];
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end else if ((mem_read || mem_write) && !m_served) begin
      m_busy <= 1'b1;
      m_cnt  <= N - 1;
    end else if (!mem_read && !mem_write) begin
      m_served <= 1'b0;
    end
  end

  // Second model: busy for 2 cycles returning 0xAA, or dead when t_live is low.
  logic t_live = 1'b1, t_busy = 1'b0, t_served = 1'b0;
  int   t_cnt = 0;
  assign t_mem_busy_wait = t_busy;

  always @(posedge clk) begin
    if (t_busy) begin
      if (t_cnt == 0) begin
        t_busy          <= 1'b0;
        t_served        <= 1'b1;
        t_mem_read_data <= 8'hAA;
      end else begin
        t_cnt <= t_cnt - 1;
      end
    end else if ((t_mem_read || t_mem_write) && !t_served && t_live) begin
      t_busy <= 1'b1;
      t_cnt  <= 1;
    end else if (!t_mem_read && !t_mem_write) begin
      t_served <= 1'b0;
    end
  end

  // Records the address of every new memory access and the last write seen.
  int         strobe_addr[$];
  logic       prev_strobe = 1'b0;
  logic [7:0] wr_addr = 8'h00, wr_data = 8'h00;
  always @(negedge clk) begin
    if ((mem_read || mem_write) && !prev_strobe) strobe_addr.push_back(int'(mem_address));
    if (mem_write) begin
      wr_addr = mem_address;
      wr_data = mem_write_data;
    end
    prev_strobe = mem_read || mem_write;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Runs the main instance until every raised request has completed, counting
  // busy cycles per port and dropping each request in its DONE cycle.
  task automatic serve(output int a_cnt, output int b_cnt);
    int guard = 0;
    a_cnt = 0;
    b_cnt = 0;
    while ((a_read || a_write || b_read || b_write) && guard < 400) begin
      @(negedge clk);
      guard++;
      if (a_busy_wait) a_cnt++; else begin a_read = 1'b0; a_write = 1'b0; end
      if (b_busy_wait) b_cnt++; else begin b_read = 1'b0; b_write = 1'b0; end
    end
    check("serve_bound", 32'(guard < 400), 32'd1);
  endtask

  task automatic t_serve(output int cnt);
    int guard = 0;
    cnt = 0;
    while ((t_a_read || t_a_write) && guard < 400) begin
      @(negedge clk);
      guard++;
      if (t_a_busy_wait) cnt++; else begin t_a_read = 1'b0; t_a_write = 1'b0; end
    end
    check("t_serve_bound", 32'(guard < 400), 32'd1);
  endtask

  int ac, bc, tc, n0, g;
  logic seen;

  initial begin
    reset = 1'b0;
    a_read = 0; a_write = 0; a_address = 0; a_write_data = 0;
    b_read = 0; b_write = 0; b_address = 0; b_write_data = 0;
    t_a_read = 0; t_a_write = 0; t_a_address = 0; t_a_write_data = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_read", 32'(mem_read), 0);
    check("rst_mem_write", 32'(mem_write), 0);
    check("rst_mem_address", 32'(mem_address), 0);
    check("rst_a_read_data", 32'(a_read_data), 0);
    check("rst_b_read_data", 32'(b_read_data), 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Port A write: 13 busy cycles for a 10-cycle memory.
    a_write = 1; a_address = 8'h04; a_write_data = 8'h11;
    serve(ac, bc);
    check("wr_a_busy_cycles", 32'(ac), 13);
    check("wr_b_busy_cycles", 32'(bc), 0);
    check("wr_mem_address", 32'(wr_addr), 32'h04);
    check("wr_mem_data", 32'(wr_data), 32'h11);
    check("wr_memory4", 32'(mem[4]), 32'h11);
    check("wr_strobe_dropped", 32'(mem_write), 0);
    check("wr_timeout_err", 32'(timeout_err), 0);
    @(posedge clk); #1;

    // Port B read back.
    b_read = 1; b_address = 8'h04;
    serve(ac, bc);
    check("rd_b_busy_cycles", 32'(bc), 13);
    check("rd_a_idle", 32'(ac), 0);
    check("rd_b_read_data", 32'(b_read_data), 32'h11);
    check("rd_a_read_data_held", 32'(a_read_data), 0);
    @(posedge clk); #1;

    // Two rounds of contention: expected order A, B, A, B.
    strobe_addr.delete();
    for (int r = 0; r < 2; r++) begin
      a_write = 1; a_address = 8'(8 + 2 * r); a_write_data = 8'(8'h22 + 8'h22 * 2 * r);
      b_write = 1; b_address = 8'(9 + 2 * r); b_write_data = 8'(8'h33 + 8'h22 * 2 * r);
      serve(ac, bc);
      check($sformatf("tie%0d_a_busy", r), 32'(ac), 13);
      check($sformatf("tie%0d_b_busy", r), 32'(bc), 27);
      @(posedge clk); #1;
    end
    check("tie_count", 32'(strobe_addr.size()), 4);
    if (strobe_addr.size() == 4) begin
      check("tie_order0", 32'(strobe_addr[0]), 8);
      check("tie_order1", 32'(strobe_addr[1]), 9);
      check("tie_order2", 32'(strobe_addr[2]), 10);
      check("tie_order3", 32'(strobe_addr[3]), 11);
    end
    check("tie_mem8", 32'(mem[8]), 32'h22);
    check("tie_mem9", 32'(mem[9]), 32'h33);
    check("tie_mem10", 32'(mem[10]), 32'h66);
    check("tie_mem11", 32'(mem[11]), 32'h77);

    // Illegal request: read and write together.
    n0 = strobe_addr.size();
    a_read = 1; a_write = 1; a_address = 8'h05;
    @(negedge clk);
    check("ill_a_busy", 32'(a_busy_wait), 0);
    repeat (4) @(negedge clk);
    check("ill_no_access", 32'(strobe_addr.size()), 32'(n0));
    a_read = 0; a_write = 0;
    @(posedge clk); #1;

    // Timeout instance: one good read, then an abort against a dead memory.
    t_a_read = 1; t_a_address = 8'h03;
    t_serve(tc);
    check("to_good_busy", 32'(tc), 5);
    check("to_good_data", 32'(t_a_read_data), 32'hAA);
    check("to_good_err", 32'(t_timeout_err), 0);
    @(posedge clk); #1;
    t_live = 1'b0;
    t_a_read = 1;
    t_serve(tc);
    check("to_abort_busy", 32'(tc), 10);
    check("to_abort_data", 32'(t_a_read_data), 0);
    check("to_abort_err", 32'(t_timeout_err), 1);
    repeat (5) @(negedge clk);
    check("to_err_sticky", 32'(t_timeout_err), 1);
    check("to_main_err_clear", 32'(timeout_err), 0);
    @(posedge clk); #1;

    // Reset during WAIT_DONE, then drain and serve the still-held request.
    a_read = 1; a_address = 8'h08;
    repeat (5) @(negedge clk);
    check("mid_strobe_on", 32'(mem_read), 1);
    reset = 1'b0;
    #1;
    check("mid_rst_mem_read", 32'(mem_read), 0);
    check("mid_rst_mem_address", 32'(mem_address), 0);
    check("mid_rst_a_read_data", 32'(a_read_data), 0);
    check("mid_rst_b_read_data", 32'(b_read_data), 0);
    check("mid_rst_t_err", 32'(t_timeout_err), 0);
    check("mid_mem_still_busy", 32'(mem_busy_wait), 1);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    g = 0;
    while (mem_busy_wait && g < 100) begin
      @(negedge clk);
      g++;
      if (mem_read || mem_write) seen = 1'b1;
    end
    check("drain_bound", 32'(g < 100), 1);
    check("drain_no_grant", 32'(seen), 0);
    check("drain_data_untouched", 32'(a_read_data), 0);
    serve(ac, bc);
    check("post_rst_read", 32'(a_read_data), 32'h22);
    check("post_rst_b_idle", 32'(bc), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
